io_port_responder: RTL
======================

Name: io_port_responder

Overview:
- Peripheral-side responder for the processor's I/O port strobes (PORT_EN, PORT_RD, ADDR) issued by the sequence controller.
- Buffers CPU writes into a TX FIFO that drains to an external valid/ready sink.
- Buffers data from an external valid/ready source into an RX FIFO that the CPU reads.
- Exposes a status register and an optional interrupt; sits beside RAM on the datapath bus.

Parameters:
DATA_W, 8, width of data words on the CPU bus and the external streams
DEPTH, 4, entries per FIFO (power of two, 2..16)
PORT_BASE, 7'h7E, ADDR of the data register; PORT_BASE+1 is the status register

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  reset; asynchronous, active-high
PORT_EN  in  1  one-cycle port access strobe from the sequence controller
PORT_RD  in  1  qualifies PORT_EN: 1 = CPU read, 0 = CPU write
ADDR  in  7  access address
WDATA  in  DATA_W  CPU write data, valid with PORT_EN & !PORT_RD
RDATA  out  DATA_W  read response data
RDATA_OE  out  1  read response valid / bus drive enable
TX_DATA  out  DATA_W  external sink data (head of TX FIFO)
TX_VALID  out  1  TX FIFO non-empty
TX_READY  in  1  sink accepts when TX_VALID & TX_READY
RX_DATA  in  DATA_W  external source data
RX_VALID  in  1  source offers a word
RX_READY  out  1  RX FIFO not full
IRQ  out  1  interrupt request (see Optional Feature)

Behaviour:
- Reset: all outputs 0. FIFOs empty, sticky flags cleared, FSM in IDLE. RX_READY rises on the first cycle after RST deasserts.
- Hit: PORT_EN high and ADDR is PORT_BASE or PORT_BASE+1. Non-hits are ignored entirely; RDATA_OE stays 0.
- Access FSM has two states, IDLE and RESP.
  - IDLE -> RESP on a read hit. Data and flags are captured in that cycle.
  - RESP drives RDATA_OE=1 with RDATA for exactly one cycle, then returns to IDLE. Read latency is 1 cycle.
  - Outside RESP, RDATA=0 and RDATA_OE=0.
  - A read hit while in RESP is served back-to-back: the FSM stays in RESP and RDATA updates.
- Data write (PORT_BASE, !PORT_RD):
  - Pushes WDATA into the TX FIFO.
  - If the TX FIFO is full, the word is dropped and sticky TX_OVF is set.
  - Completes in the same cycle and produces no response.
- Data read (PORT_BASE, PORT_RD):
  - Pops the RX FIFO head and returns it.
  - If the RX FIFO is empty, returns 0 and sets sticky RX_UNF.
- Status read (PORT_BASE+1): bit0 RX_NE, bit1 TX_FULL, bit2 TX_EMPTY, bit3 RX_FULL, bit4 TX_OVF, bit5 RX_UNF, upper bits 0. Values are sampled in the access cycle.
- Status write (PORT_BASE+1, !PORT_RD): WDATA[4]=1 clears TX_OVF and WDATA[5]=1 clears RX_UNF. Other bits are ignored.
- TX side:
  - TX_VALID = TX FIFO not empty; TX_DATA = head.
  - A pop occurs on TX_VALID & TX_READY.
  - TX_DATA is held stable while TX_VALID & !TX_READY.
- RX side:
  - RX_READY = RX FIFO not full.
  - A push occurs on RX_VALID & RX_READY. No data is lost; the source is backpressured.
- Simultaneous events:
  - CPU push and sink pop on the same TX FIFO: both succeed, count unchanged. This holds even when the FIFO is full: the push is accepted because a pop frees space in that cycle, and TX_OVF is not set.
  - CPU pop and source push on the same RX FIFO: both succeed. When the RX FIFO is empty, the CPU read still returns 0 with RX_UNF set, and the incoming word is stored.
  - A flag clear and a flag set in the same cycle: set wins.
- FIFO pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH. Full = pointers differ only in the MSB.
- RST asserted mid-operation (including during RESP): immediate return to the reset state. Buffered data is discarded.

Optional Feature:
- Macro: PORT_IRQ_EN.
- Defined:
  - IRQ is registered and equals (RX_NE | TX_OVF | RX_UNF).
  - It rises one cycle after the causing event.
  - It falls one cycle after the condition clears.
- Undefined: IRQ is tied to 0 and no IRQ logic is generated.
- The port list is identical in both builds.

Decomposition:
- Package portpackage: enum ACC_STATE {IDLE, RESP}; status bit index constants (ST_RX_NE=0 .. ST_RX_UNF=5); default PORT_BASE.
- Sub-module port_fifo(DATA_W, DEPTH):
  - Ports: CLK, RST, push, pop, wdata, rdata (head), full, empty.
  - Instantiated twice, once for TX and once for RX.
- Top-level holds the address decode, access FSM, sticky flags and IRQ.

Test Plan:
- Reset then read status -> RDATA_OE pulses 1 cycle after PORT_EN with RDATA=8'h04 (TX_EMPTY only); all other outputs 0.
- With TX_READY=0, write 8'hA5, 8'h3C -> TX_VALID=1, TX_DATA=8'hA5 held. Raise TX_READY for 2 cycles -> sink receives A5 then 3C, then TX_VALID=0.
- Write 5 words with DEPTH=4 and TX_READY=0 -> 5th dropped; status=8'h12. Write 8'h10 to status -> reads 8'h02.
- Source pushes 8'h11, 8'h22 -> two data reads return 11 then 22. A third read returns 0 and status shows RX_UNF (8'h24).
- Fill RX (4 words) -> RX_READY=0 while RX_VALID held. A CPU read pops one entry; RX_READY=1 on the next cycle and the pending word is accepted.
- Assert RST during RESP with both FIFOs non-empty -> outputs 0 immediately. The post-reset status read returns 8'h04. With PORT_IRQ_EN, the RX push raises IRQ one cycle later.

Source files
------------

// File: rtl/io_port_responder_pkg.sv
// Shared types and constants for the I/O port responder: access FSM states,
// status register bit positions and the default port address.
package portpackage;

    typedef enum logic {IDLE, RESP} ACC_STATE;

    localparam int ST_RX_NE    = 0;
    localparam int ST_TX_FULL  = 1;
    localparam int ST_TX_EMPTY = 2;
    localparam int ST_RX_FULL  = 3;
    localparam int ST_TX_OVF   = 4;
    localparam int ST_RX_UNF   = 5;

    localparam logic [6:0] DEF_PORT_BASE = 7'h7E;

endpackage

// File: rtl/port_fifo.sv
// Synchronous FIFO with extra-MSB pointers; the caller guarantees that it
// never pushes when full (without a pop) and never pops when empty.
module port_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       wr_ptr, rd_ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is left unreset; empty gating at the top hides stale contents.
    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/io_port_responder.sv
// CPU port responder: data/status registers over TX/RX FIFOs with one-cycle
// read response. Define PORT_IRQ_EN to build the registered interrupt output.
module io_port_responder
    import portpackage::*;
#(
    parameter int         DATA_W    = 8,
    parameter int         DEPTH     = 4,
    parameter logic [6:0] PORT_BASE = DEF_PORT_BASE
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              PORT_EN,
    input  logic              PORT_RD,
    input  logic [6:0]        ADDR,
    input  logic [DATA_W-1:0] WDATA,
    output logic [DATA_W-1:0] RDATA,
    output logic              RDATA_OE,
    output logic [DATA_W-1:0] TX_DATA,
    output logic              TX_VALID,
    input  logic              TX_READY,
    input  logic [DATA_W-1:0] RX_DATA,
    input  logic              RX_VALID,
    output logic              RX_READY,
    output logic              IRQ
);
    ACC_STATE          state;
    logic              tx_full, tx_empty, rx_full, rx_empty;
    logic [DATA_W-1:0] tx_head, rx_head;
    logic              tx_ovf, rx_unf, rdy_en;

    logic hit_data, hit_stat, rd_hit;
    logic tx_push, tx_pop, rx_push, rx_pop;
    logic tx_ovf_set, rx_unf_set, tx_ovf_clr, rx_unf_clr;
    logic [DATA_W-1:0] status, rd_val;

    assign hit_data = PORT_EN && (ADDR == PORT_BASE);
    assign hit_stat = PORT_EN && (ADDR == PORT_BASE + 7'd1);
    assign rd_hit   = (hit_data || hit_stat) && PORT_RD;

    // A sink pop in the same cycle frees a slot, so a write to a full FIFO is still taken.
    assign tx_pop     = !tx_empty && TX_READY;
    assign tx_push    = hit_data && !PORT_RD && (!tx_full || tx_pop);
    assign tx_ovf_set = hit_data && !PORT_RD && tx_full && !tx_pop;
    assign tx_ovf_clr = hit_stat && !PORT_RD && WDATA[ST_TX_OVF];

    assign rx_push    = RX_VALID && RX_READY;
    assign rx_pop     = hit_data && PORT_RD && !rx_empty;
    assign rx_unf_set = hit_data && PORT_RD && rx_empty;
    assign rx_unf_clr = hit_stat && !PORT_RD && WDATA[ST_RX_UNF];

    assign TX_VALID = !tx_empty;
    assign TX_DATA  = tx_empty ? '0 : tx_head;
    assign RX_READY = rdy_en && !rx_full;

    always_comb begin
        status              = '0;
        status[ST_RX_NE]    = !rx_empty;
        status[ST_TX_FULL]  = tx_full;
        status[ST_TX_EMPTY] = tx_empty;
        status[ST_RX_FULL]  = rx_full;
        status[ST_TX_OVF]   = tx_ovf;
        status[ST_RX_UNF]   = rx_unf;
    end

    assign rd_val = hit_stat ? status : (rx_empty ? '0 : rx_head);

    port_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_tx_fifo (
        .CLK(CLK), .RST(RST), .push(tx_push), .pop(tx_pop),
        .wdata(WDATA), .rdata(tx_head), .full(tx_full), .empty(tx_empty)
    );

    port_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_rx_fifo (
        .CLK(CLK), .RST(RST), .push(rx_push), .pop(rx_pop),
        .wdata(RX_DATA), .rdata(rx_head), .full(rx_full), .empty(rx_empty)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            RDATA    <= '0;
            RDATA_OE <= 1'b0;
        end else if (rd_hit) begin
            state    <= RESP;
            RDATA    <= rd_val;
            RDATA_OE <= 1'b1;
        end else begin
            state    <= IDLE;
            RDATA    <= '0;
            RDATA_OE <= 1'b0;
        end
    end

    // Set has priority over a same-cycle clear.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tx_ovf <= 1'b0;
            rx_unf <= 1'b0;
            rdy_en <= 1'b0;
        end else begin
            tx_ovf <= tx_ovf_set || (tx_ovf && !tx_ovf_clr);
            rx_unf <= rx_unf_set || (rx_unf && !rx_unf_clr);
            rdy_en <= 1'b1;
        end
    end

`ifdef PORT_IRQ_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) IRQ <= 1'b0;
        else     IRQ <= !rx_empty || tx_ovf || rx_unf;
    end
`else
    assign IRQ = 1'b0;
`endif

endmodule
